rc4_decrypt_engine: RTL and testbench

Parametrised RC4 keystream/decrypt engine for the key-search datapath. After the S-array is initialised and key-scheduled, it runs the RC4 PRGA over a runtime-selectable message length. Each byte is XORed with the encrypted ROM and the plaintext is written to the decrypted RAM. An optional plaintext filter aborts early on the first illegal character, so a key-search controller can reject a candidate key without decrypting the full message.

---
 rtl/rc4_decrypt_engine.sv | 164 ++++++++++++++++
 tb/tb_rc4_decrypt_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_engine.sv
// RC4 PRGA decrypt engine: XORs the keystream with the encrypted ROM and writes plaintext to the output RAM.
// Latency: 10*len+2 cycles from start to done, or 10*(m+1)+1 when the filter rejects byte m.
// Backpressure: none; start is accepted only in IDLE, and start while busy is ignored.
module rc4_decrypt_engine #(
    parameter int MSG_LEN_MAX = 32,
    parameter int LEN_W       = 6,
    parameter int MEM_AW      = 5,
    parameter int CHECK_EN    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    output logic              busy,
    output logic              done,
    output logic              result_ok,
    output logic [LEN_W-1:0]  fail_index,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MEM_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MEM_AW-1:0] out_address,
    output logic [7:0]        out_data,
    output logic              out_wren
);

    typedef enum logic [3:0] {
        IDLE, INIT, CHECK, RD_SI_A, RD_SI_B, RD_SJ_A, RD_SJ_B,
        WR_SI, WR_SJ, RD_F_A, RD_F_B, WR_OUT, DONE
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MSG_LEN_MAX);

    state_t           state, state_nxt;
    logic [7:0]       i, j, si, sj, f, c;
    logic [LEN_W-1:0] k, len;
    logic [7:0]       pt;
    logic             pt_legal, pt_reject;

    // Filter accepts only space and lowercase ASCII letters.
    assign pt        = f ^ c;
    assign pt_legal  = (pt == 8'h20) || ((pt >= 8'h61) && (pt <= 8'h7a));
    assign pt_reject = (CHECK_EN != 0) && !pt_legal;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            result_ok  <= 1'b0;
            fail_index <= '0;
            i          <= '0;
            j          <= '0;
            si         <= '0;
            sj         <= '0;
            f          <= '0;
            c          <= '0;
            k          <= '0;
            len        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) len <= (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
                end
                INIT: begin
                    i          <= '0;
                    j          <= '0;
                    k          <= '0;
                    result_ok  <= 1'b1;
                    fail_index <= '0;
                end
                CHECK: begin
                    if (k != len) i <= i + 8'd1;
                end
                RD_SI_B: begin
                    si <= s_q;
                    j  <= j + s_q;
                end
                RD_SJ_B: sj <= s_q;
                RD_F_B: begin
                    f <= s_q;
                    c <= rom_q;
                end
                WR_OUT: begin
                    if (pt_reject) begin
                        result_ok  <= 1'b0;
                        fail_index <= k;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        s_address   = '0;
        s_data      = '0;
        s_wren      = 1'b0;
        rom_address = '0;
        out_address = '0;
        out_data    = '0;
        out_wren    = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = CHECK;
            CHECK:   state_nxt = (k == len) ? DONE : RD_SI_A;
            RD_SI_A: begin
                s_address = i;
                state_nxt = RD_SI_B;
            end
            RD_SI_B: begin
                s_address = i;
                state_nxt = RD_SJ_A;
            end
            RD_SJ_A: begin
                s_address = j;
                state_nxt = RD_SJ_B;
            end
            RD_SJ_B: begin
                s_address = j;
                state_nxt = WR_SI;
            end
            WR_SI: begin
                s_address = i;
                s_data    = sj;
                s_wren    = 1'b1;
                state_nxt = WR_SJ;
            end
            // i==j gives si==sj, so the swap degenerates to a harmless rewrite.
            WR_SJ: begin
                s_address = j;
                s_data    = si;
                s_wren    = 1'b1;
                state_nxt = RD_F_A;
            end
            RD_F_A: begin
                s_address   = si + sj;
                rom_address = MEM_AW'(k);
                state_nxt   = RD_F_B;
            end
            RD_F_B: begin
                s_address   = si + sj;
                rom_address = MEM_AW'(k);
                state_nxt   = WR_OUT;
            end
            WR_OUT: begin
                out_address = MEM_AW'(k);
                out_data    = pt;
                out_wren    = 1'b1;
                state_nxt   = pt_reject ? DONE : CHECK;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_rc4_decrypt_engine.sv
// Randomised RC4 decrypt bench: a plain-array RC4 reference predicts bytes, status and latency per run.
module tb_rc4_decrypt_engine;

    localparam int LEN_W  = 6;
    localparam int MEM_AW = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset_n, start, start_b;
    logic [LEN_W-1:0]  msg_len;
    logic              busy, done, result_ok, s_wren, out_wren;
    logic [LEN_W-1:0]  fail_index;
    logic [7:0]        s_address, s_data, s_q, rom_q, out_data;
    logic [MEM_AW-1:0] rom_address, out_address;
    logic              busy_b, done_b, result_ok_b, s_wren_b, out_wren_b;
    logic [LEN_W-1:0]  fail_index_b;
    logic [7:0]        s_address_b, s_data_b, s_q_b, rom_q_b, out_data_b;
    logic [MEM_AW-1:0] rom_address_b, out_address_b;

    rc4_decrypt_engine #(.MSG_LEN_MAX(32), .LEN_W(LEN_W), .MEM_AW(MEM_AW), .CHECK_EN(1)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .msg_len(msg_len),
        .busy(busy), .done(done), .result_ok(result_ok), .fail_index(fail_index),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
        .rom_address(rom_address), .rom_q(rom_q),
        .out_address(out_address), .out_data(out_data), .out_wren(out_wren)
    );

    rc4_decrypt_engine #(.MSG_LEN_MAX(32), .LEN_W(LEN_W), .MEM_AW(MEM_AW), .CHECK_EN(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .msg_len(msg_len),
        .busy(busy_b), .done(done_b), .result_ok(result_ok_b), .fail_index(fail_index_b),
        .s_address(s_address_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
        .rom_address(rom_address_b), .rom_q(rom_q_b),
        .out_address(out_address_b), .out_data(out_data_b), .out_wren(out_wren_b)
    );

    // Memories: one writer process each; the host stages S contents in sh and loads them in one cycle.
    logic [7:0] smem [0:255];
    logic [7:0] smem_b [0:255];
    logic [7:0] sh [0:255];
    logic [7:0] rom [0:31];
    logic [7:0] omem [0:31];
    logic [7:0] omem_b [0:31];
    logic       host_load = 1'b0;
    logic       host_load_b = 1'b0;

    always @(posedge clock) begin
        if (host_load) begin
            for (int x = 0; x < 256; x++) smem[x] <= sh[x];
            for (int x = 0; x < 32; x++) omem[x] <= 8'hee;
        end else if (s_wren) smem[s_address] <= s_data;
        if (out_wren) omem[out_address] <= out_data;
        s_q   <= smem[s_address];
        rom_q <= rom[rom_address];
    end

    always @(posedge clock) begin
        if (host_load_b) begin
            for (int x = 0; x < 256; x++) smem_b[x] <= sh[x];
            for (int x = 0; x < 32; x++) omem_b[x] <= 8'hee;
        end else if (s_wren_b) smem_b[s_address_b] <= s_data_b;
        if (out_wren_b) omem_b[out_address_b] <= out_data_b;
        s_q_b   <= smem_b[s_address_b];
        rom_q_b <= rom[rom_address_b];
    end

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state for the current run.
    logic [15:0] exp_q[$];
    logic        exp_ok;
    int          exp_fail, exp_lat, e0, done_el;
    logic [7:0]  ms [0:255];
    logic        mon_on = 1'b0;

    task automatic model(input int len_in, input bit chk);
        logic [7:0] s [0:255];
        logic [7:0] i, j, t, p, idx;
        int n;
        n = (len_in > 32) ? 32 : len_in;
        s = smem;
        i = 0;
        j = 0;
        exp_q.delete();
        exp_ok   = 1'b1;
        exp_fail = 0;
        exp_lat  = 10 * n + 2;
        for (int k = 0; k < n; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            idx = s[i] + s[j];
            p = s[idx] ^ rom[k];
            exp_q.push_back({8'(k), p});
            if (chk && !(p == 8'h20 || (p >= 8'h61 && p <= 8'h7a))) begin
                exp_ok   = 1'b0;
                exp_fail = k;
                exp_lat  = 10 * (k + 1) + 1;
                break;
            end
        end
        ms = s;
    endtask

    // Builds a ROM whose plaintext is legal except (optionally) at bad_at.
    task automatic make_rom(input int n, input int bad_at);
        logic [7:0] s [0:255];
        logic [7:0] i, j, t, idx, pt;
        int r;
        s = smem;
        i = 0;
        j = 0;
        for (int k = 0; k < n; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            idx = s[i] + s[j];
            r = $urandom_range(0, 26);
            pt = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            if (k == bad_at) pt = 8'(8'h30 + $urandom_range(0, 9));
            rom[k] = s[idx] ^ pt;
        end
    endtask

    int         mon_el;
    logic [15:0] mon_w;
    always @(negedge clock) begin
        if (mon_on) begin
            mon_el = edge_cnt - e0;
            if (mon_el >= 0) begin
                check("busy", busy, (mon_el < exp_lat));
                check("done", done, (mon_el == exp_lat));
                if (done && done_el < 0) done_el = mon_el;
                if (mon_el == exp_lat) begin
                    check("result_ok", result_ok, exp_ok);
                    check("fail_index", fail_index, exp_fail);
                end
                if (exp_lat == 2) check("len0_no_s_wren", s_wren, 0);
                if (out_wren) begin
                    check("write_expected", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mon_w = exp_q.pop_front();
                        check("out_address", out_address, mon_w[15:8]);
                        check("out_data", out_data, mon_w[7:0]);
                    end
                end
            end
        end
    end

    task automatic load_s();
        @(negedge clock); host_load = 1'b1;
        @(negedge clock); host_load = 1'b0;
    endtask

    task automatic identity_s();
        for (int x = 0; x < 256; x++) sh[x] = 8'(x);
    endtask

    task automatic shuffle_s();
        logic [7:0] t;
        int y;
        identity_s();
        for (int x = 255; x > 0; x--) begin
            y = $urandom_range(0, x);
            t = sh[x]; sh[x] = sh[y]; sh[y] = t;
        end
    endtask

    task automatic run(input int len, input int pulse_at);
        int bad;
        model(len, 1'b1);
        done_el = -1;
        @(negedge clock);
        start   = 1'b1;
        msg_len = LEN_W'(len);
        e0      = edge_cnt + 1;
        mon_on  = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        msg_len = LEN_W'($urandom);
        for (int c = 1; c < exp_lat + 4; c++) begin
            start = (c == pulse_at);
            if (c == pulse_at) msg_len = 6'd1;
            @(negedge clock);
        end
        start  = 1'b0;
        mon_on = 1'b0;
        check("done_seen_latency", done_el, exp_lat);
        check("writes_drained", exp_q.size(), 0);
        check("result_ok_held", result_ok, exp_ok);
        check("fail_index_held", fail_index, exp_fail);
        bad = 0;
        for (int x = 0; x < 256; x++) if (smem[x] !== ms[x]) bad++;
        check("s_final_perm", bad, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, n, bad_at;
        logic quiet;
        logic [7:0] b0;

        reset_n = 1'b0; start = 1'b0; start_b = 1'b0; msg_len = '0;
        repeat (3) @(negedge clock);
        check("reset_ctrl", {busy, done, result_ok, fail_index, s_wren, out_wren}, 0);
        check("reset_bus", {s_address, s_data, rom_address, out_address, out_data}, 0);
        reset_n = 1'b1;

        // Identity S, all-'a' plaintext.
        identity_s(); load_s();
        rom[0] = 8'h63; rom[1] = 8'h64; rom[2] = 8'h66;
        run(3, 0);
        check("t1_latency", done_el, 32);
        check("t1_out", {omem[0], omem[1], omem[2]}, 24'h616161);
        check("t1_ok", result_ok, 1);
        check("t1_s", {smem[2], smem[3], smem[5]}, 24'h030502);

        // Uppercase second byte trips the filter.
        identity_s(); load_s();
        rom[1] = 8'h44;
        run(3, 0);
        check("t2_latency", done_el, 21);
        check("t2_out", {omem[0], omem[1], omem[2]}, 24'h6141ee);
        check("t2_status", {result_ok, fail_index}, {1'b0, 6'd1});

        // Same stimulus with the filter disabled.
        identity_s();
        @(negedge clock); host_load_b = 1'b1;
        @(negedge clock); host_load_b = 1'b0;
        @(negedge clock); start_b = 1'b1; msg_len = 6'd3;
        @(negedge clock); start_b = 1'b0;
        cnt = 0;
        while (!done_b && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        check("nochk_latency", cnt, 32);
        check("nochk_status", {result_ok_b, fail_index_b}, {1'b1, 6'd0});
        check("nochk_out", {omem_b[0], omem_b[1], omem_b[2]}, 24'h614161);

        // Zero length.
        run(0, 0);
        check("len0_latency", done_el, 2);

        // Clamp 63 -> 32 with a stray start mid-run.
        shuffle_s(); load_s();
        make_rom(32, -1);
        run(63, 100);
        check("clamp_latency", done_el, 322);

        for (int it = 0; it < 6; it++) begin
            shuffle_s(); load_s();
            n = $urandom_range(1, 32);
            bad_at = ($urandom_range(0, 1) != 0) ? $urandom_range(0, n - 1) : -1;
            make_rom(n, bad_at);
            run(n, 0);
        end

        // Reset during byte 1's WR_SI.
        shuffle_s(); load_s();
        make_rom(8, -1);
        model(8, 1'b1);
        b0 = exp_q[0][7:0];
        @(negedge clock); start = 1'b1; msg_len = 6'd8;
        @(negedge clock); start = 1'b0;
        repeat (16) @(negedge clock);
        check("rst_in_wr_si", s_wren, 1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("midrst_ctrl", {busy, done, result_ok, fail_index, s_wren, out_wren}, 0);
        check("midrst_bus", {s_address, s_data, rom_address, out_address, out_data}, 0);
        quiet = 1'b0;
        repeat (30) begin
            @(negedge clock);
            quiet = quiet | s_wren | out_wren | busy;
        end
        check("quiet_after_rst", quiet, 0);
        check("midrst_out", {omem[0], omem[1]}, {b0, 8'hee});

        shuffle_s(); load_s();
        n = $urandom_range(1, 32);
        make_rom(n, -1);
        run(n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
